// File: rtl/dt_serializer_if.sv
// FIFO-read / UART-write handshake bundle for dt_serializer.
interface dt_serializer_if #(
  parameter int DATA_PACKET_WIDTH = 51,
  parameter int UART_DATA_WIDTH   = 8
);
  logic [DATA_PACKET_WIDTH-1:0] data_packet;
  logic                         f_empty;
  logic                         rd_en;
  logic                         tx_ready;
  logic [UART_DATA_WIDTH-1:0]   data_byte;
  logic                         we;
  logic                         busy;
  logic                         pkt_done;
  logic [15:0]                  pkt_count;

  // serializer side
  modport master (
    input  data_packet, f_empty, tx_ready,
    output rd_en, data_byte, we, busy, pkt_done, pkt_count
  );

  // FIFO + UART side
  modport slave (
    output data_packet, f_empty, tx_ready,
    input  rd_en, data_byte, we, busy, pkt_done, pkt_count
  );
endinterface

// File: rtl/dt_serializer.sv
// Pops one packet from a FIFO and writes it to a UART byte by byte,
// optionally prefixed with a start-of-frame byte.
module dt_serializer #(
  parameter int          DATA_PACKET_WIDTH = 51,
  parameter int          UART_DATA_WIDTH   = 8,
  parameter int          MSB_FIRST         = 1,
  parameter int          SOF_ENABLE        = 0,
  parameter int unsigned SOF_BYTE          = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  dt_serializer_if.master bus
);
  localparam int NUM_BYTES = (DATA_PACKET_WIDTH + UART_DATA_WIDTH - 1) / UART_DATA_WIDTH;
  localparam int PAD_W     = NUM_BYTES * UART_DATA_WIDTH;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [UART_DATA_WIDTH-1:0] SOF_VAL  = UART_DATA_WIDTH'(SOF_BYTE);

  typedef enum logic [2:0] {IDLE, READ, LOAD, SOF, SEND} state_t;

  state_t                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [PAD_W-1:0]           pkt_q;
  logic [15:0]                cnt_q;
  logic [UART_DATA_WIDTH-1:0] cur_byte;
  logic                       sending;
  int                         shamt;

  // Sequencer: fetch, capture, optional SOF, then walk the byte index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pkt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (!bus.f_empty) state_q <= READ;
        READ: state_q <= LOAD;
        LOAD: begin
          // zero-extension supplies the MSB-end padding
          pkt_q   <= PAD_W'(bus.data_packet);
          idx_q   <= '0;
          state_q <= (SOF_ENABLE != 0) ? SOF : SEND;
        end
        SOF: if (bus.tx_ready) state_q <= SEND;
        SEND: begin
          if (bus.tx_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              cnt_q   <= cnt_q + 16'd1;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte select: index 0 maps to the top byte when sending MSB first.
  always_comb begin
    if (MSB_FIRST != 0) shamt = (NUM_BYTES - 1 - int'(idx_q)) * UART_DATA_WIDTH;
    else                shamt = int'(idx_q) * UART_DATA_WIDTH;
    cur_byte = UART_DATA_WIDTH'(pkt_q >> shamt);
  end

  // Output byte is only meaningful in SOF/SEND; zero elsewhere.
  always_comb begin
    bus.data_byte = '0;
    case (state_q)
      SOF:     bus.data_byte = SOF_VAL;
      SEND:    bus.data_byte = cur_byte;
      default: bus.data_byte = '0;
    endcase
  end

  assign sending      = (state_q == SOF) || (state_q == SEND);
  assign bus.rd_en    = (state_q == READ);
  assign bus.busy     = (state_q != IDLE);
  assign bus.we       = sending && bus.tx_ready;
  assign bus.pkt_done = (state_q == SEND) && bus.tx_ready && (idx_q == LAST_IDX);
  assign bus.pkt_count = cnt_q;
endmodule

// File: doc/dt_serializer.md
DT_SERIALIZER -- requirements
Module: dt_serializer

Interface
REQ-001 The block SHALL have parameter DATA_PACKET_WIDTH, default 51, the packet width in bits (legal range >=1).
REQ-002 The block SHALL have parameter UART_DATA_WIDTH, default 8, the output byte width in bits (legal range >=1).
REQ-003 The block SHALL have parameter MSB_FIRST, default 1; 1 = most-significant byte first, 0 = least-significant byte first.
REQ-004 The block SHALL have parameter SOF_ENABLE, default 0; 1 = prefix each packet with a start-of-frame byte.
REQ-005 The block SHALL have parameter SOF_BYTE, default 8'hA5, the start-of-frame value, zero-extended or truncated to UART_DATA_WIDTH.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 data_packet  input  DATA_PACKET_WIDTH  FIFO read data, valid in the cycle after rd_en.
REQ-009 f_empty  input  1  FIFO empty flag.
REQ-010 rd_en  output  1  FIFO read strobe, one-cycle pulse.
REQ-011 tx_ready  input  1  UART transmitter can accept a byte this cycle.
REQ-012 data_byte  output  UART_DATA_WIDTH  byte presented to the UART.
REQ-013 we  output  1  byte write strobe; data_byte is accepted in every cycle with we=1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 pkt_done  output  1  one-cycle pulse in the cycle the last byte of a packet is written.
REQ-016 pkt_count  output  16  count of completed packets.

Function
REQ-017 NUM_BYTES SHALL equal ceil(DATA_PACKET_WIDTH/UART_DATA_WIDTH); the packet is zero-padded at the MSB end up to NUM_BYTES*UART_DATA_WIDTH bits.
REQ-018 The FSM SHALL have states IDLE, READ, LOAD, SOF, SEND.
REQ-019 IDLE: when f_empty=0, go to READ; otherwise stay in IDLE.
REQ-020 READ: assert rd_en for exactly this one cycle, then go to LOAD.
REQ-021 LOAD: capture data_packet into an internal register and clear the byte index; go to SOF if SOF_ENABLE=1, else to SEND.
REQ-022 SOF: data_byte SHALL equal SOF_BYTE; when tx_ready=1, drive we=1 and go to SEND; otherwise hold.
REQ-023 SEND: data_byte SHALL equal byte[index] of the captured packet, where index 0 is the MSB byte if MSB_FIRST=1 and the LSB byte if MSB_FIRST=0.
REQ-024 SEND: when tx_ready=1, drive we=1 and advance index; when tx_ready=0, keep we=0 and hold index and data_byte.
REQ-025 SEND: a write of index NUM_BYTES-1 SHALL assert pkt_done, increment pkt_count, and return the FSM to IDLE.
REQ-026 we SHALL be the combinational AND of (state==SOF or state==SEND) and tx_ready; consecutive bytes may be written on back-to-back cycles.
REQ-027 rd_en SHALL never assert outside READ, so the minimum packet-to-packet gap is 3 cycles (IDLE, READ, LOAD).
REQ-028 Changes on f_empty or data_packet outside IDLE and LOAD SHALL have no effect.
REQ-029 pkt_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-030 If DATA_PACKET_WIDTH <= UART_DATA_WIDTH, NUM_BYTES = 1 and the packet is sent as a single zero-extended byte.
REQ-031 If DATA_PACKET_WIDTH is an exact multiple of UART_DATA_WIDTH, no padding is applied.
REQ-032 In IDLE, READ and LOAD, data_byte SHALL be 0.

Reset
REQ-033 While rst_n=0: state=IDLE, index=0, captured packet=0, pkt_count=0, and rd_en, we, busy, pkt_done and data_byte all 0.
REQ-034 Reset asserted mid-packet SHALL discard the remaining bytes immediately.
REQ-035 After reset release, the block SHALL resume from IDLE with no spurious rd_en or we.

Verification
REQ-036 Defaults; one packet 51'h7123456789ABC; tx_ready=1 -> rd_en for 1 cycle; we high 7 consecutive cycles with bytes 07,12,34,56,78,9A,BC; pkt_done on the 7th; pkt_count=1.
REQ-037 MSB_FIRST=0, same packet -> bytes BC,9A,78,56,34,12,07.
REQ-038 SOF_ENABLE=1; tx_ready toggling 1/0 every cycle -> A5 followed by the 7 bytes; we only in tx_ready=1 cycles; data_byte stable while stalled.
REQ-039 Three packets queued (f_empty=0 throughout) -> three rd_en pulses, each only after the prior pkt_done; gap of 3 cycles between bursts; pkt_count=3.
REQ-040 rst_n pulsed low after the 3rd byte -> no further we; pkt_count=0; the next packet is sent complete from byte 0.
REQ-041 DATA_PACKET_WIDTH=16, UART_DATA_WIDTH=8 -> 2 bytes with no padding; pkt_count preloaded by 65535 packets wraps to 0 on the next pkt_done.
